expr_tokenizer: RTL and testbench

- Upstream stage of the calculator: converts an ASCII infix-expression byte stream into the 3-bit opcode / 16-bit operand token stream the calculator consumes.
- Accumulates decimal digits into operands and maps operator characters to opcodes.
- Valid/ready on both sides, one token per handshake.
- Sticky error flag for malformed input.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/expr_tokenizer_char_classifier.sv | 31 +++
 rtl/expr_tokenizer.sv | 173 +++++++++++++++++
 tb/tb_expr_tokenizer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: token opcodes, ASCII codes
// and the tokenizer state encoding.
package calc_pkg;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_MULT    = 3'b001;
    localparam logic [2:0] OP_LPAREN  = 3'b010;
    localparam logic [2:0] OP_RPAREN  = 3'b011;
    localparam logic [2:0] OP_OPERAND = 3'b100;
    localparam logic [2:0] OP_END     = 3'b111;

    localparam logic [7:0] ASCII_TAB    = 8'h09;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_LPAREN = 8'h28;
    localparam logic [7:0] ASCII_RPAREN = 8'h29;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_9      = 8'h39;
    localparam logic [7:0] ASCII_EQUAL  = 8'h3D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_EMIT_NUM,
        S_EMIT_OP,
        S_ERROR
    } state_t;

endpackage

// File: rtl/expr_tokenizer_char_classifier.sv
// Combinational character classifier: splits an ASCII byte into digit,
// whitespace and operator classes and gives the digit value / opcode.
module char_classifier
    import calc_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_digit,
    output logic [3:0] digit_val,
    output logic       is_space,
    output logic       is_op,
    output logic [2:0] opcode
);

    always_comb begin
        is_digit  = (ch >= ASCII_0) && (ch <= ASCII_9);
        digit_val = ch[3:0];
        is_space  = 1'b0;
        is_op     = 1'b0;
        opcode    = OP_ADD;
        case (ch)
            ASCII_SPACE, ASCII_TAB, ASCII_CR: is_space = 1'b1;
            ASCII_PLUS:   begin is_op = 1'b1; opcode = OP_ADD;    end
            ASCII_STAR:   begin is_op = 1'b1; opcode = OP_MULT;   end
            ASCII_LPAREN: begin is_op = 1'b1; opcode = OP_LPAREN; end
            ASCII_RPAREN: begin is_op = 1'b1; opcode = OP_RPAREN; end
            ASCII_EQUAL, ASCII_LF: begin is_op = 1'b1; opcode = OP_END; end
            default: ;
        endcase
    end

endmodule

// File: rtl/expr_tokenizer.sv
// ASCII infix-expression tokenizer: digits -> operand tokens, operators -> opcodes.
// Optional PAREN_CHECK_EN adds a parenthesis depth check.
//
// state      | meaning
// S_IDLE     | no digits pending, accepting characters
// S_ACC      | digits pending in acc, accepting characters
// S_EMIT_NUM | operand token presented, op_reg waiting behind it
// S_EMIT_OP  | operator / end token presented
// S_ERROR    | malformed input seen, dead until rst
module expr_tokenizer
    import calc_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_char,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [2:0]            tok_opcode,
    output logic [DATA_WIDTH-1:0] tok_operand,
    output logic                  tok_valid,
    input  logic                  tok_ready,
    output logic                  overflow,
    output logic                  err
);

    localparam int ACC_WIDTH = DATA_WIDTH + 4;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] acc;
    logic [2:0]            op_reg;
    logic                  op_bad;
    logic                  is_digit, is_space, is_op;
    logic [3:0]            digit_val;
    logic [2:0]            char_op;
    logic                  accept, tok_fire, paren_bad;
    logic [ACC_WIDTH-1:0]  acc_mul;
    logic                  acc_sat;

    char_classifier u_classifier (
        .ch        (in_char),
        .is_digit  (is_digit),
        .digit_val (digit_val),
        .is_space  (is_space),
        .is_op     (is_op),
        .opcode    (char_op)
    );

    assign accept   = in_valid && in_ready;
    assign tok_fire = tok_valid && tok_ready;
    assign acc_mul  = ACC_WIDTH'(acc) * ACC_WIDTH'(10) + ACC_WIDTH'(digit_val);
    assign acc_sat  = |acc_mul[ACC_WIDTH-1:DATA_WIDTH];

`ifdef PAREN_CHECK_EN
    logic [DEPTH_WIDTH-1:0] depth;

    always_comb begin
        paren_bad = 1'b0;
        if (is_op) begin
            case (char_op)
                OP_LPAREN: paren_bad = &depth;
                OP_RPAREN: paren_bad = (depth == '0);
                OP_END:    paren_bad = (depth != '0);
                default:   paren_bad = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
        end else if (accept && is_op && !paren_bad) begin
            if (char_op == OP_LPAREN)
                depth <= depth + DEPTH_WIDTH'(1);
            else if (char_op == OP_RPAREN)
                depth <= depth - DEPTH_WIDTH'(1);
        end else if (state == S_EMIT_OP && tok_fire && op_reg == OP_END) begin
            depth <= '0;
        end
    end
`else
    logic unused_depth_width;
    assign unused_depth_width = DEPTH_WIDTH[0];
    assign paren_bad          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_ACC: begin
                if (accept) begin
                    if (is_digit)
                        state_next = S_ACC;
                    else if (is_op) begin
                        // a bad paren behind pending digits still lets the number out first
                        if (state == S_ACC)
                            state_next = S_EMIT_NUM;
                        else if (paren_bad)
                            state_next = S_ERROR;
                        else
                            state_next = S_EMIT_OP;
                    end else if (!is_space)
                        state_next = S_ERROR;
                end
            end
            S_EMIT_NUM: if (tok_fire) state_next = op_bad ? S_ERROR : S_EMIT_OP;
            S_EMIT_OP:  if (tok_fire) state_next = S_IDLE;
            S_ERROR:    state_next = S_ERROR;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            op_reg   <= OP_ADD;
            op_bad   <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                if (is_digit) begin
                    acc <= acc_sat ? '1 : acc_mul[DATA_WIDTH-1:0];
                    if (acc_sat)
                        overflow <= 1'b1;
                end else if (is_op) begin
                    op_reg <= char_op;
                    op_bad <= paren_bad;
                    if (paren_bad && state == S_IDLE)
                        err <= 1'b1;
                end else if (!is_space) begin
                    err <= 1'b1;
                    acc <= '0;
                end
            end
            if (state == S_EMIT_NUM && tok_fire) begin
                acc <= '0;
                if (op_bad)
                    err <= 1'b1;
            end
        end
    end

    always_comb begin
        in_ready    = 1'b0;
        tok_valid   = 1'b0;
        tok_opcode  = OP_ADD;
        tok_operand = '0;
        case (state)
            S_IDLE, S_ACC: in_ready = 1'b1;
            S_EMIT_NUM: begin
                tok_valid   = 1'b1;
                tok_opcode  = OP_OPERAND;
                tok_operand = acc;
            end
            S_EMIT_OP: begin
                tok_valid  = 1'b1;
                tok_opcode = op_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_expr_tokenizer.sv
// Self-checking bench for expr_tokenizer: table of expression strings with
// hand-computed token lists, plus hand-written reset / hold sequences.
module tb_expr_tokenizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_char;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  tok_opcode;
    logic [15:0] tok_operand;
    logic        tok_valid;
    logic        tok_ready;
    logic        overflow;
    logic        err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string stim;
        int    stall;
        bit    rst_before;
        bit    exp_ovf;
        bit    exp_err;
        int    tfirst;
        int    tcount;
    } vec_t;

    vec_t        vecs[$];
    logic [18:0] exp_tok[$];
    int          tfirst_pending;

    expr_tokenizer #(.DATA_WIDTH(16), .DEPTH_WIDTH(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_char     (in_char),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tok_opcode  (tok_opcode),
        .tok_operand (tok_operand),
        .tok_valid   (tok_valid),
        .tok_ready   (tok_ready),
        .overflow    (overflow),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void vbegin();
        tfirst_pending = exp_tok.size();
    endfunction

    function automatic void tk(logic [2:0] op, logic [15:0] val);
        exp_tok.push_back({op, val});
    endfunction

    function automatic void vend(string s, int stall, bit rb, bit ovf, bit e);
        vec_t v;
        v.stim = s; v.stall = stall; v.rst_before = rb; v.exp_ovf = ovf; v.exp_err = e;
        v.tfirst = tfirst_pending;
        v.tcount = exp_tok.size() - tfirst_pending;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; tok_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; drives one cycle per iteration and records handshakes.
    task automatic run_vec(int vi);
        vec_t        t;
        int          idx = 0, quiet = 0, cyc = 0, stall_cnt = 0;
        bit          busy, hold_prev = 0;
        logic [18:0] hold_val = '0;
        logic [18:0] got[$];
        t = vecs[vi];
        if (t.rst_before) do_reset();
        while (quiet < 12 && cyc < 400) begin
            in_valid  = (idx < t.stim.len());
            in_char   = in_valid ? t.stim[idx] : 8'h00;
            tok_ready = tok_valid && (stall_cnt >= t.stall);
            if (hold_prev) begin
                check($sformatf("v%0d hold_valid", vi), {31'd0, tok_valid}, 32'd1);
                check($sformatf("v%0d hold_stable", vi), {13'd0, tok_opcode, tok_operand}, {13'd0, hold_val});
                check($sformatf("v%0d hold_in_ready", vi), {31'd0, in_ready}, 32'd0);
            end
            busy = 1'b0;
            if (in_valid && in_ready) begin idx++; busy = 1'b1; end
            if (tok_valid && tok_ready) begin
                got.push_back({tok_opcode, tok_operand});
                stall_cnt = 0; hold_prev = 0; busy = 1'b1;
            end else if (tok_valid) begin
                stall_cnt++; hold_prev = 1; hold_val = {tok_opcode, tok_operand}; busy = 1'b1;
            end else begin
                hold_prev = 0;
            end
            quiet = busy ? 0 : quiet + 1;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0; tok_ready = 1'b0;
        check($sformatf("v%0d timeout", vi), {31'd0, cyc < 400}, 32'd1);
        check($sformatf("v%0d tok_count", vi), got.size(), t.tcount);
        for (int k = 0; k < t.tcount && k < got.size(); k++)
            check($sformatf("v%0d tok%0d", vi, k), {13'd0, got[k]}, {13'd0, exp_tok[t.tfirst + k]});
        check($sformatf("v%0d overflow", vi), {31'd0, overflow}, {31'd0, t.exp_ovf});
        check($sformatf("v%0d err", vi), {31'd0, err}, {31'd0, t.exp_err});
        check($sformatf("v%0d in_ready", vi), {31'd0, in_ready}, {31'd0, !t.exp_err});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; tok_ready = 1'b0;
        do_reset();

        check("rst tok_valid", {31'd0, tok_valid}, 32'd0);
        check("rst tok_opcode", {29'd0, tok_opcode}, 32'd0);
        check("rst tok_operand", {16'd0, tok_operand}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst overflow", {31'd0, overflow}, 32'd0);
        check("rst err", {31'd0, err}, 32'd0);

        vbegin(); tk(3'd4, 16'd12); tk(3'd0, 0); tk(3'd4, 16'd3); tk(3'd7, 0);
        vend("12+3=", 0, 1, 0, 0);
        vbegin(); tk(3'd2, 0); tk(3'd4, 16'd2); tk(3'd1, 0); tk(3'd4, 16'd34); tk(3'd3, 0); tk(3'd7, 0);
        vend("(2*34)\n", 0, 0, 0, 0);
        vbegin(); tk(3'd4, 16'd65535); tk(3'd7, 0);
        vend("70000=", 0, 0, 1, 0);
        vbegin(); tk(3'd4, 16'd5); tk(3'd7, 0);
        vend("5=", 0, 0, 1, 0);
        vbegin(); tk(3'd4, 16'd4); tk(3'd0, 0); tk(3'd4, 16'd5); tk(3'd7, 0);
        vend("4+5=", 5, 1, 0, 0);
        vbegin();
        vend("7a+1", 0, 0, 0, 1);
        vbegin(); tk(3'd4, 16'd1); tk(3'd7, 0);
        vend("1=", 0, 1, 0, 0);
        vbegin();
        vend("98", 0, 1, 0, 0);
        vbegin(); tk(3'd4, 16'd3); tk(3'd7, 0);
        vend("3=", 0, 1, 0, 0);
        vbegin(); tk(3'd4, 16'd123); tk(3'd0, 0); tk(3'd7, 0); tk(3'd7, 0);
        vend("1 2\t3\015+==", 0, 0, 0, 0);
        vbegin(); tk(3'd4, 16'd65535); tk(3'd7, 0);
        vend("65535=", 0, 0, 0, 0);
        vbegin(); tk(3'd4, 16'd65535); tk(3'd7, 0);
        vend("65536=", 0, 0, 1, 0);
        vbegin(); tk(3'd4, 16'd7); tk(3'd1, 0); tk(3'd2, 0); tk(3'd4, 16'd1); tk(3'd3, 0); tk(3'd7, 0);
        vend("007*(1)\n", 0, 1, 0, 0);
`ifdef PAREN_CHECK_EN
        vbegin(); tk(3'd4, 16'd1);
        vend("1)=", 0, 1, 0, 1);
`else
        vbegin(); tk(3'd4, 16'd1); tk(3'd3, 0); tk(3'd7, 0);
        vend("1)=", 0, 1, 0, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        // Reset while an operand token is being held must discard it.
        do_reset();
        in_valid = 1'b1; in_char = "5";
        @(negedge clk);
        in_char = "+";
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("hold tok_valid", {31'd0, tok_valid}, 32'd1);
        check("hold tok", {13'd0, tok_opcode, tok_operand}, {13'd0, 3'd4, 16'd5});
        check("hold in_ready", {31'd0, in_ready}, 32'd0);
        do_reset();
        check("midrst tok_valid", {31'd0, tok_valid}, 32'd0);
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst tok_operand", {16'd0, tok_operand}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
